rr_addr_arbiter: RTL and testbench
==================================

Name: rr_addr_arbiter

Overview:
- N-way round-robin arbiter for address requests: several requesters share one downstream address port.
- Each request carries a valid flag and an address.
- The winning request is captured in a single-entry output register, so the output is fully registered and sustains one transfer per cycle.
- Sits between the memory-request clients and the address consumer; replaces fixed-priority sharing so that no requester can starve.

Parameters:
- N_IN, 4, number of requesters (2..16)
- ADDR_W, 27, address width
- IDX_W, 2, width of the chosen index; must equal ceil(log2(N_IN)), min 1

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- io_in_valid  input  N_IN  per-requester request valid
- io_in_ready  output  N_IN  per-requester accept
- io_in_bits_valid  input  N_IN  per-requester payload valid flag
- io_in_bits_bits_addr  input  N_IN*ADDR_W  addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- io_out_ready  input  1  downstream accept
- io_out_valid  output  1  output register holds a request
- io_out_bits_valid  output  1  registered payload valid flag
- io_out_bits_bits_addr  output  ADDR_W  registered address
- io_chosen  output  IDX_W  index of the requester whose request is in the output register

Behaviour:
- Clock and reset: one clock; reset asynchronous, active-low. The reset assertion effect below is immediate, with no clock edge needed.
- Reset values: io_out_valid=0, io_out_bits_valid=0, io_out_bits_bits_addr=0, io_chosen=0, last-grant pointer=N_IN-1. As a result, requester 0 has top priority after reset.
- State:
  - full: the output register is occupied.
  - out_data: valid flag, address and chosen index.
  - last: last granted index, IDX_W bits.
- can_load = !full | io_out_ready. The output register accepts a new entry when it is empty or is draining in the same cycle.
- Grant (combinational):
  - Scan indices last+1, last+2, ..., wrapping modulo N_IN and ending at last.
  - The first i with io_in_valid[i]=1 wins.
  - No winner when all valids are 0.
- io_in_ready[i] = can_load & (i == winner). At most one ready is high at a time. All readys are 0 when there is no request.
  - io_in_ready may depend on io_in_valid of other requesters.
  - A requester must not make its valid depend on its own ready.
- Fire: in_fire = any(io_in_valid & io_in_ready). Out_fire = io_out_valid & io_out_ready.
- On in_fire, at the next clock edge:
  - full=1.
  - out_data captures the winner's bits_valid, addr and index.
  - last=winner.
- On out_fire without in_fire: full=0. out_data keeps its value; it is a don't-care once invalid but is held, not cleared.
- Simultaneous out_fire and in_fire: the register reloads with the new request. There is no bubble, so throughput is 1 per cycle.
- Latency: a request accepted at edge k appears on io_out_* during cycle k+1 (one cycle).
- Backpressure: while io_out_valid=1 and io_out_ready=0, all io_out_* are held stable, all io_in_ready=0, and last does not change.
- Pointer behaviour:
  - last updates only on in_fire.
  - Idle cycles do not rotate priority.
- Fairness: with all requesters continuously valid and io_out_ready=1, grants cycle 0,1,...,N_IN-1,0,...
- Starvation bound: a continuously valid requester is granted within N_IN accepted transfers.
- Non-power-of-two N_IN: indices >= N_IN are never produced. Wrap is modulo N_IN, not 2^IDX_W.
- Reset mid-operation:
  - Any held request is dropped: io_out_valid=0 immediately.
  - The pointer returns to N_IN-1.
  - The requester side sees no handshake during reset.
- io_out_bits_valid is payload only and does not qualify the handshake. A request with bits_valid=0 is arbitrated and forwarded like any other.

Test Plan:
- Reset, then no requests → io_out_valid=0, io_in_ready=0000, io_chosen=0, addr=0. Assert reset (drive low) while io_out_valid=1 → io_out_valid drops to 0 with no clock edge.
- Requester 2 valid alone, addr=0x1234567, io_out_ready=1, for 5 cycles → io_in_ready[2]=1 every cycle. io_out_valid=1 from the second cycle, io_chosen=2, addr=0x1234567, one transfer per cycle.
- All 4 requesters valid, addrs 0x10/0x20/0x30/0x40, io_out_ready=1 → io_chosen sequence 0,1,2,3,0,1 and addr sequence 0x10,0x20,0x30,0x40,0x10.
- Output held with io_out_ready=0 for 3 cycles while requesters 1 and 3 valid → io_out_* unchanged, io_in_ready=0000. Release io_out_ready → next grant follows last+1 order with no lost or duplicated transfer.
- Wrap: last=3 after a grant, then only requesters 0 and 3 valid → requester 0 is granted first, then 3.
- N_IN=3 instance, all valid → io_chosen cycles 0,1,2,0 and never reaches 3. A request with bits_valid=0 is forwarded with io_out_bits_valid=0 and io_out_valid=1.

Source files
------------

// File: rtl/rr_addr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_addr_arbiter
//   N-way round-robin arbiter feeding one registered address output port.
//   The winner of each arbitration is captured in a single-entry output
//   register that can reload in the same cycle it drains, giving one
//   transfer per cycle with one cycle of latency.
//
// Ports:
//   clock                 rising-edge clock
//   reset                 asynchronous, active-low reset
//   io_in_valid[N_IN]     per-requester request valid
//   io_in_ready[N_IN]     per-requester accept (one-hot or zero)
//   io_in_bits_valid      per-requester payload valid flag
//   io_in_bits_bits_addr  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   io_out_ready          downstream accept
//   io_out_valid          output register occupied
//   io_out_bits_valid     registered payload valid flag
//   io_out_bits_bits_addr registered address
//   io_chosen             index of the requester held in the output register
// ---------------------------------------------------------------------------
module rr_addr_arbiter #(
    parameter int N_IN   = 4,
    parameter int ADDR_W = 27,
    parameter int IDX_W  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_IN-1:0]          io_in_valid,
    output logic [N_IN-1:0]          io_in_ready,
    input  logic [N_IN-1:0]          io_in_bits_valid,
    input  logic [N_IN*ADDR_W-1:0]   io_in_bits_bits_addr,
    input  logic                     io_out_ready,
    output logic                     io_out_valid,
    output logic                     io_out_bits_valid,
    output logic [ADDR_W-1:0]        io_out_bits_bits_addr,
    output logic [IDX_W-1:0]         io_chosen
);

    logic              full;
    logic              out_bv;
    logic [ADDR_W-1:0] out_addr;
    logic [IDX_W-1:0]  chosen_q;
    logic [IDX_W-1:0]  last;

    logic [N_IN-1:0]   above_mask;
    logic [N_IN-1:0]   hi_vec;
    logic [N_IN-1:0]   pick;
    logic [N_IN-1:0]   grant_oh;
    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic              can_load;
    logic              in_fire;
    logic              sel_bv;
    logic [ADDR_W-1:0] sel_addr;

    logic [ADDR_W-1:0] addr_arr [N_IN];

    for (genvar g = 0; g < N_IN; g++) begin : g_addr
        assign addr_arr[g] = io_in_bits_bits_addr[g*ADDR_W +: ADDR_W];
    end

    // Round-robin search split in two: requesters above 'last' take
    // priority; if none is valid, the lowest valid index wins (wrap).
    // When last = N_IN-1 the shifted bit falls off the top, the mask
    // becomes zero and the search starts again from index 0.
    always_comb begin
        above_mask = ~((N_IN'(2) << last) - N_IN'(1));
        hi_vec     = io_in_valid & above_mask;
        pick       = (|hi_vec) ? hi_vec : io_in_valid;
        grant_oh   = pick & (~pick + N_IN'(1));
        any_req    = |io_in_valid;
    end

    always_comb begin
        winner = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant_oh[IDX_W'(i)]) begin
                winner = winner | IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_bv   = io_in_bits_valid[winner];
        sel_addr = addr_arr[winner];
    end

    // Holding reset in can_load keeps the requester side from seeing a
    // handshake while reset is asserted.
    assign can_load    = reset & (~full | io_out_ready);
    assign in_fire     = can_load & any_req;
    assign io_in_ready = can_load ? grant_oh : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full     <= 1'b0;
            out_bv   <= 1'b0;
            out_addr <= '0;
            chosen_q <= '0;
            last     <= IDX_W'(N_IN - 1);
        end else if (in_fire) begin
            full     <= 1'b1;
            out_bv   <= sel_bv;
            out_addr <= sel_addr;
            chosen_q <= winner;
            last     <= winner;
        end else if (io_out_ready) begin
            full <= 1'b0;
        end
    end

    assign io_out_valid          = full;
    assign io_out_bits_valid     = out_bv;
    assign io_out_bits_bits_addr = out_addr;
    assign io_chosen             = chosen_q;

endmodule

// File: tb/tb_rr_addr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_addr_arbiter
//   Directed bench for rr_addr_arbiter: a 4-way instance driven from a
//   vector table, plus hand sequences for asynchronous reset and a 3-way
//   instance with a bits_valid=0 payload.
// ---------------------------------------------------------------------------
module tb_rr_addr_arbiter;

    logic          clock;
    logic          reset;

    logic [3:0]    valid4;
    logic [3:0]    ready4;
    logic [3:0]    bv4;
    logic [107:0]  addr4;
    logic          oready4;
    logic          ov4;
    logic          obv4;
    logic [26:0]   oaddr4;
    logic [1:0]    ch4;

    logic [2:0]    valid3;
    logic [2:0]    ready3;
    logic [2:0]    bv3;
    logic [80:0]   addr3;
    logic          oready3;
    logic          ov3;
    logic          obv3;
    logic [26:0]   oaddr3;
    logic [1:0]    ch3;

    int tests;
    int fails;

    rr_addr_arbiter #(.N_IN(4), .ADDR_W(27), .IDX_W(2)) dut4 (
        .clock                 (clock),
        .reset                 (reset),
        .io_in_valid           (valid4),
        .io_in_ready           (ready4),
        .io_in_bits_valid      (bv4),
        .io_in_bits_bits_addr  (addr4),
        .io_out_ready          (oready4),
        .io_out_valid          (ov4),
        .io_out_bits_valid     (obv4),
        .io_out_bits_bits_addr (oaddr4),
        .io_chosen             (ch4)
    );

    rr_addr_arbiter #(.N_IN(3), .ADDR_W(27), .IDX_W(2)) dut3 (
        .clock                 (clock),
        .reset                 (reset),
        .io_in_valid           (valid3),
        .io_in_ready           (ready3),
        .io_in_bits_valid      (bv3),
        .io_in_bits_bits_addr  (addr3),
        .io_out_ready          (oready3),
        .io_out_valid          (ov3),
        .io_out_bits_valid     (obv3),
        .io_out_bits_bits_addr (oaddr3),
        .io_chosen             (ch3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  valid;
        logic        oready;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic        exp_bv;
        logic [1:0]  exp_ch;
        logic [26:0] exp_addr;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Addresses: requester 0..3 -> 0x10, 0x20, 0x30, 0x40
        //             valid  ordy  exp_rdy  ov    bv    ch     addr
        // reset state, idle
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 27'h0};
        // all valid: fairness 0,1,2,3,0,1
        tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 27'h10};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 27'h20};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 27'h30};
        tbl[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 27'h40};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 27'h10};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 27'h20};
        // drain, then idle with data held
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 27'h20};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 27'h20};
        // requester 2 alone, one transfer per cycle
        tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 27'h30};
        tbl[10] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 27'h30};
        tbl[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 27'h30};
        // backpressure with requesters 1 and 3 waiting
        tbl[12] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 27'h30};
        tbl[13] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 27'h30};
        tbl[14] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 27'h30};
        // release: last=2 so requester 3 is next
        tbl[15] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 27'h40};
        // wrap from last=3 with 0 and 3 valid: 0 then 3
        tbl[16] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 27'h10};
        tbl[17] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 27'h40};
        tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3, 27'h40};

        valid4  = '0;
        bv4     = 4'b1111;
        addr4   = {27'h40, 27'h30, 27'h20, 27'h10};
        oready4 = 1'b0;
        valid3  = '0;
        bv3     = 3'b101;
        addr3   = {27'h300, 27'h200, 27'h100};
        oready3 = 1'b0;

        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            valid4  = tbl[i].valid;
            oready4 = tbl[i].oready;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(ready4), 32'(tbl[i].exp_ready));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(ov4), 32'(tbl[i].exp_ov));
            chk($sformatf("v%0d out_bits_valid", i), 32'(obv4), 32'(tbl[i].exp_bv));
            chk($sformatf("v%0d chosen", i), 32'(ch4), 32'(tbl[i].exp_ch));
            chk($sformatf("v%0d addr", i), 32'(oaddr4), 32'(tbl[i].exp_addr));
        end

        // Load requester 1 (last becomes 1), then assert reset mid-cycle.
        @(negedge clock);
        valid4  = 4'b0010;
        oready4 = 1'b1;
        #1;
        chk("pre-reset in_ready", 32'(ready4), 32'h2);
        @(posedge clock);
        #1;
        chk("pre-reset out_valid", 32'(ov4), 32'h1);
        chk("pre-reset chosen", 32'(ch4), 32'h1);
        valid4  = 4'b1111;
        oready4 = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async reset out_valid", 32'(ov4), 32'h0);
        chk("async reset out_bits_valid", 32'(obv4), 32'h0);
        chk("async reset chosen", 32'(ch4), 32'h0);
        chk("async reset addr", 32'(oaddr4), 32'h0);
        chk("async reset in_ready", 32'(ready4), 32'h0);
        chk("async reset n3 out_valid", 32'(ov3), 32'h0);
        @(negedge clock);
        reset   = 1'b1;
        oready4 = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(ready4), 32'h1);
        @(posedge clock);
        #1;
        chk("post-reset chosen", 32'(ch4), 32'h0);
        chk("post-reset out_valid", 32'(ov4), 32'h1);
        @(negedge clock);
        valid4 = '0;

        // Three-way instance, all valid; requester 1 carries bits_valid=0.
        valid3  = 3'b111;
        oready3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            chk($sformatf("n3 step%0d in_ready", k), 32'(ready3), 32'(1 << (k % 3)));
            @(posedge clock);
            #1;
            chk($sformatf("n3 step%0d out_valid", k), 32'(ov3), 32'h1);
            chk($sformatf("n3 step%0d chosen", k), 32'(ch3), 32'(k % 3));
            chk($sformatf("n3 step%0d addr", k), 32'(oaddr3), 32'(((k % 3) + 1) * 32'h100));
            chk($sformatf("n3 step%0d out_bits_valid", k), 32'(obv3), ((k % 3) == 1) ? 32'h0 : 32'h1);
        end
        @(negedge clock);
        valid3 = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
